// File: rtl/a2d_arbiter_pkg.sv
// Shared types and constants for the A2D front-end arbiter.
package a2d_arb_pkg;

   typedef enum logic [2:0] {IDLE, START, WAIT, DONE, SETTLE} arb_state_t;

   localparam int REQ_MOTION = 0;
   localparam int REQ_BATT   = 1;
   localparam int REQ_DIAG   = 2;

   localparam int RES_W = 12;
   localparam int CH_W  = 3;

   // Counter/index width that never collapses to zero bits.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/a2d_arbiter_if.sv
// Requester-side and A2D_intf-side signals of the arbiter, bundled with modports.
interface a2d_arbiter_if
   import a2d_arb_pkg::*;
#(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]      req;
   logic [CH_W*NUM_REQ-1:0] chnnl_req;
   logic [NUM_REQ-1:0]      gnt;
   logic [NUM_REQ-1:0]      done;
   logic [RES_W-1:0]        res_out;
   logic                    timeout_err;
   logic                    busy;
   logic                    strt_cnv;
   logic [CH_W-1:0]         chnnl;
   logic                    cnv_cmplt;
   logic [RES_W-1:0]        A2D_res;

   modport master (
      input  req, chnnl_req, cnv_cmplt, A2D_res,
      output gnt, done, res_out, timeout_err, busy, strt_cnv, chnnl
   );

   modport slave (
      output req, chnnl_req, cnv_cmplt, A2D_res,
      input  gnt, done, res_out, timeout_err, busy, strt_cnv, chnnl
   );
endinterface

// File: rtl/a2d_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req at or after ptr, wrapping.
module rr_pick
   import a2d_arb_pkg::*;
#(
   parameter int N  = 3,
   parameter int PW = clog2_min1(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  sel,
   output logic [PW-1:0] idx,
   output logic          any
);

   int best;
   int best_d;
   int d;

   // Rotated distance from ptr; smallest distance among set requests wins.
   always_comb begin
      best   = 0;
      best_d = N;
      d      = 0;
      for (int i = 0; i < N; i++) begin
         d = (i >= int'(ptr)) ? i - int'(ptr) : i + N - int'(ptr);
         if (req[i] && d < best_d) begin
            best   = i;
            best_d = d;
         end
      end
      any = (best_d < N);
      idx = PW'(best);
      for (int i = 0; i < N; i++) sel[i] = any && (best == i);
   end

endmodule

// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D_intf among requesters, with a
// cnv_cmplt watchdog and a post-conversion settle gap.
module a2d_arbiter
   import a2d_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int TIMEOUT = 4096,
   parameter int GUARD   = 32
) (
   input  logic          clk,
   input  logic          rst,
   a2d_arbiter_if.master bus
);

   localparam int PW = clog2_min1(NUM_REQ);
   localparam int WW = clog2_min1(TIMEOUT);
   localparam int GW = clog2_min1(GUARD + 1);

   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
   localparam logic [GW-1:0] G_LAST  = GW'((GUARD > 0) ? GUARD - 1 : 0);
   localparam logic [PW-1:0] P_LAST  = PW'(NUM_REQ - 1);

   arb_state_t state, state_nxt;

   logic [NUM_REQ-1:0]           sel;
   logic [PW-1:0]                sel_idx;
   logic                         sel_any;
   logic [NUM_REQ-1:0]           gnt_r;
   logic [PW-1:0]                gidx;
   logic [PW-1:0]                ptr;
   logic [WW-1:0]                wd;
   logic [GW-1:0]                gcnt;
   logic [RES_W-1:0]             res_r;
   logic [CH_W-1:0]              chnnl_r;
   logic                         tmo_flag;
   logic                         load_gnt;
   logic                         cap;
   logic                         tmo;
   logic [NUM_REQ-1:0][CH_W-1:0] chq;

   assign chq = bus.chnnl_req;

   rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
      .req (bus.req),
      .ptr (ptr),
      .sel (sel),
      .idx (sel_idx),
      .any (sel_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_gnt  = 1'b0;
      cap       = 1'b0;
      tmo       = 1'b0;
      case (state)
         IDLE: begin
            if (sel_any) begin
               load_gnt  = 1'b1;
               state_nxt = START;
            end
         end
         START: state_nxt = WAIT;
         WAIT: begin
            // A completion on the expiry cycle still counts as success.
            if (bus.cnv_cmplt) begin
               cap       = 1'b1;
               state_nxt = DONE;
            end else if (wd == WD_LAST) begin
               tmo       = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = (GUARD == 0) ? IDLE : SETTLE;
         SETTLE:  if (gcnt == G_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_r    <= '0;
         gidx     <= '0;
         ptr      <= '0;
         wd       <= '0;
         gcnt     <= '0;
         res_r    <= '0;
         chnnl_r  <= '0;
         tmo_flag <= 1'b0;
      end else begin
         // wd holds cycles elapsed since the strt_cnv cycle.
         if (load_gnt) begin
            gnt_r    <= sel;
            gidx     <= sel_idx;
            chnnl_r  <= chq[sel_idx];
            tmo_flag <= 1'b0;
            wd       <= '0;
         end else if (state inside {START, WAIT}) begin
            wd <= wd + WW'(1);
         end

         if (cap) res_r    <= bus.A2D_res;
         if (tmo) tmo_flag <= 1'b1;

         if (state == DONE) begin
            gnt_r <= '0;
            ptr   <= (gidx == P_LAST) ? '0 : gidx + PW'(1);
         end

         if (state == SETTLE) gcnt <= gcnt + GW'(1);
         else                 gcnt <= '0;
      end
   end

   assign bus.gnt         = gnt_r;
   assign bus.done        = (state == DONE) ? gnt_r : '0;
   assign bus.timeout_err = (state == DONE) && tmo_flag;
   assign bus.busy        = (state != IDLE);
   assign bus.strt_cnv    = (state == START);
   assign bus.chnnl       = chnnl_r;
   assign bus.res_out     = res_r;

endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed bench for a2d_arbiter; completions are scored against a queue of expectations.
module tb_a2d_arbiter;
   import a2d_arb_pkg::*;

   localparam int NR  = 3;
   localparam int TMO = 4096;
   localparam int GRD = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   a2d_arbiter_if #(.NUM_REQ(NR)) bus();

   a2d_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO), .GUARD(GRD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [NR-1:0] done;
      logic [11:0]   res;
      logic          terr;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errs   = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [NR-1:0] dn, input logic [11:0] r, input logic te);
      exp_t e;
      e.done = dn;
      e.res  = r;
      e.terr = te;
      sb.push_back(e);
   endtask

   task automatic wait_strt(input string tag, output int t);
      int n = 0;
      do begin tick(); n++; end while (bus.strt_cnv !== 1'b1 && n < 200);
      chk(tag, 32'(bus.strt_cnv), 32'd1);
      t = cyc;
   endtask

   task automatic wait_done(input string tag, input int max, output int t);
      int n = 0;
      do begin tick(); n++; end while (bus.done === '0 && n < max);
      chk(tag, 32'(|bus.done), 32'd1);
      t = cyc;
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      do begin tick(); n++; end while (bus.busy !== 1'b0 && n < 200);
      chk(tag, 32'(bus.busy), 32'd0);
   endtask

   task automatic pulse_cmplt(input logic [11:0] r);
      bus.cnv_cmplt = 1'b1;
      bus.A2D_res   = r;
      tick();
      bus.cnv_cmplt = 1'b0;
      bus.A2D_res   = 12'h000;
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done !== '0) begin
         if (sb.size() == 0) begin
            checks++;
            errs++;
            $error("FAIL sb_unexpected: got done=%b want no completion", bus.done);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_done", 32'(bus.done), 32'(e.done));
            chk("sb_res", 32'(bus.res_out), 32'(e.res));
            chk("sb_terr", 32'(bus.timeout_err), 32'(e.terr));
         end
      end
   end

   initial begin
      int s, d, e, bad, n;
      int chv[NR];
      chv = '{3, 5, 6};
      d = 0;
      bus.req       = '0;
      bus.chnnl_req = '0;
      bus.cnv_cmplt = 1'b0;
      bus.A2D_res   = '0;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_strt", 32'(bus.strt_cnv), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_chnnl", 32'(bus.chnnl), 0);
      chk("rst_res", 32'(bus.res_out), 0);
      chk("rst_terr", 32'(bus.timeout_err), 0);
      rst = 1'b0;
      tick();

      // single request, 40-cycle conversion
      bus.req       = 3'b001;
      bus.chnnl_req = 9'd4;
      tick();
      s = cyc;
      chk("t1_gnt", 32'(bus.gnt), 32'(1 << REQ_MOTION));
      chk("t1_strt", 32'(bus.strt_cnv), 1);
      chk("t1_chnnl", 32'(bus.chnnl), 4);
      push(3'b001, 12'hABC, 1'b0);
      bad = 0;
      repeat (40) begin
         tick();
         if (bus.strt_cnv !== 1'b0 || bus.chnnl !== 3'd4 || bus.gnt !== 3'b001) bad++;
      end
      chk("t1_hold", 32'(bad), 0);
      pulse_cmplt(12'hABC);
      chk("t1_done", 32'(bus.done), 1);
      chk("t1_res", 32'(bus.res_out), 32'h0ABC);
      chk("t1_terr", 32'(bus.timeout_err), 0);
      chk("t1_lat", 32'(cyc - s), 41);
      bus.req = 3'b000;
      tick();
      chk("t1_done_pulse", 32'(bus.done), 0);
      chk("t1_gnt_clr", 32'(bus.gnt), 0);
      wait_idle("t1_idle", n);
      chk("t1_settle", 32'(n), GRD);

      // contention from a fresh pointer: order 0,1,2,0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req       = 3'b111;
      bus.chnnl_req = {3'd6, 3'd5, 3'd3};
      for (int k = 0; k < 4; k++) begin
         e = k % NR;
         wait_strt("t2_strt", s);
         chk("t2_gnt", 32'(bus.gnt), 32'(1 << e));
         chk("t2_chnnl", 32'(bus.chnnl), 32'(chv[e]));
         if (k > 0) chk("t2_gap", 32'(s - d), GRD + 2);
         push(NR'(1 << e), 12'(12'h100 + k), 1'b0);
         bad = 0;
         repeat (5 + k) begin
            tick();
            if (bus.strt_cnv !== 1'b0) bad++;
         end
         chk("t2_onestrt", 32'(bad), 0);
         pulse_cmplt(12'(12'h100 + k));
         d = cyc;
         chk("t2_done", 32'(bus.done), 32'(1 << e));
      end
      bus.req = 3'b000;
      wait_idle("t2_idle", n);

      // watchdog expiry on requester 1, then late completions are dropped
      bus.req       = 3'b010;
      bus.chnnl_req = {3'd0, 3'd2, 3'd0};
      wait_strt("t3_strt", s);
      chk("t3_gnt", 32'(bus.gnt), 32'(1 << REQ_BATT));
      push(3'b010, 12'h103, 1'b1);
      wait_done("t3_done", TMO + 100, d);
      chk("t3_lat", 32'(d - s), TMO);
      chk("t3_terr", 32'(bus.timeout_err), 1);
      chk("t3_res", 32'(bus.res_out), 32'h103);
      bus.req = 3'b000;
      tick();
      pulse_cmplt(12'hFFF);
      chk("t3_late_settle", 32'(bus.res_out), 32'h103);
      wait_idle("t3_idle", n);
      pulse_cmplt(12'hEEE);
      chk("t3_late_idle_busy", 32'(bus.busy), 0);
      chk("t3_late_idle_res", 32'(bus.res_out), 32'h103);

      // req dropped and channel changed mid-WAIT
      bus.req       = 3'b001;
      bus.chnnl_req = 9'd1;
      wait_strt("t4_strt", s);
      chk("t4_gnt", 32'(bus.gnt), 1);
      push(3'b001, 12'h5A5, 1'b0);
      repeat (10) tick();
      bus.req       = 3'b000;
      bus.chnnl_req = 9'h1FF;
      repeat (5) tick();
      chk("t4_chnnl", 32'(bus.chnnl), 1);
      chk("t4_gnt_held", 32'(bus.gnt), 1);
      pulse_cmplt(12'h5A5);
      chk("t4_done", 32'(bus.done), 1);
      chk("t4_res", 32'(bus.res_out), 32'h5A5);
      wait_idle("t4_idle", n);

      // completion on the watchdog's last cycle is a success
      bus.req       = 3'b100;
      bus.chnnl_req = {3'd3, 6'd0};
      wait_strt("t5_strt", s);
      chk("t5_gnt", 32'(bus.gnt), 32'(1 << REQ_DIAG));
      push(3'b100, 12'h777, 1'b0);
      repeat (TMO - 1) tick();
      pulse_cmplt(12'h777);
      chk("t5_lat", 32'(cyc - s), TMO);
      chk("t5_done", 32'(bus.done), 32'h4);
      chk("t5_terr", 32'(bus.timeout_err), 0);
      chk("t5_res", 32'(bus.res_out), 32'h777);
      bus.req = 3'b000;
      wait_idle("t5_idle", n);

      // async reset in WAIT, then pointer restarts at 0
      bus.req       = 3'b001;
      bus.chnnl_req = 9'd5;
      wait_strt("t6_strt", s);
      repeat (10) tick();
      rst = 1'b1;
      #1;
      chk("t6_gnt", 32'(bus.gnt), 0);
      chk("t6_strt", 32'(bus.strt_cnv), 0);
      chk("t6_busy", 32'(bus.busy), 0);
      chk("t6_done", 32'(bus.done), 0);
      chk("t6_res", 32'(bus.res_out), 0);
      chk("t6_chnnl", 32'(bus.chnnl), 0);
      bus.req = 3'b110;
      tick();
      rst = 1'b0;
      wait_strt("t6_strt2", s);
      chk("t6_first", 32'(bus.gnt), 32'(1 << REQ_BATT));
      push(3'b010, 12'h321, 1'b0);
      repeat (3) tick();
      pulse_cmplt(12'h321);
      chk("t6_done2", 32'(bus.done), 32'h2);
      bus.req = 3'b000;
      wait_idle("t6_idle", n);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
